// File: rtl/iiitb_pcps_pkg.sv
// rtl/iiitb_pcps_pkg.sv - shared FSM state encoding and seven-segment digit constants
package iiitb_pcps_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PASS  = 3'd1,
        WRONG_PASS = 3'd2,
        RIGHT_PASS = 3'd3,
        STOP       = 3'd4,
        LOCKOUT    = 3'd5
    } state_e;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/iiitb_seg7.sv
// rtl/iiitb_seg7.sv - BCD digit to active-low seven-segment pattern
module iiitb_seg7
    import iiitb_pcps_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/iiitb_pcps.sv
// rtl/iiitb_pcps.sv - password-gated parking entry controller with occupancy count and free-slot display
module iiitb_pcps
    import iiitb_pcps_pkg::*;
#(
    parameter int CAPACITY    = 9,
    parameter int PW_W        = 2,
    parameter int PASS_1      = 1,
    parameter int PASS_2      = 2,
    parameter int MAX_TRIES   = 3,
    parameter int WAIT_CYCLES = 15,
    parameter int LOCK_CYCLES = 31
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            sensor_entrance,
    input  logic                            sensor_exit,
    input  logic                            sensor_depart,
    input  logic [PW_W-1:0]                 password_1,
    input  logic [PW_W-1:0]                 password_2,
    input  logic                            pw_valid,
    output logic                            GREEN_LED,
    output logic                            RED_LED,
    output logic                            FULL,
    output logic                            LOCKED,
    output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
    output logic [6:0]                      HEX_1,
    output logic [6:0]                      HEX_2
);

    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(WAIT_CYCLES + 1);
    localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

    state_e             state_q, state_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               blink_q, blink_d;

    logic               pw_match;
    logic               full;
    logic [TRY_W-1:0]   tries_inc;
    logic               entry_inc;
    logic               depart_dec;
    logic [6:0]         free_slots;
    logic [3:0]         tens_digit;
    logic [3:0]         units_digit;

    assign pw_match   = (password_1 == PW_W'(PASS_1)) && (password_2 == PW_W'(PASS_2));
    assign full       = (occ_q == OCC_W'(CAPACITY));
    assign tries_inc  = tries_q + TRY_W'(1);
    assign entry_inc  = (state_q == RIGHT_PASS) && sensor_exit;
    assign depart_dec = sensor_depart && (occ_q != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tries_q <= '0;
            timer_q <= '0;
            lock_q  <= '0;
            occ_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            lock_q  <= lock_d;
            occ_q   <= occ_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        timer_d = timer_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (sensor_entrance && !full) begin
                    state_d = WAIT_PASS;
                    tries_d = '0;
                    timer_d = '0;
                end
            end
            WAIT_PASS, WRONG_PASS: begin
                if (pw_valid) begin
                    timer_d = '0;
                    if (pw_match) begin
                        state_d = RIGHT_PASS;
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == TRY_W'(MAX_TRIES)) begin
                            state_d = LOCKOUT;
                            lock_d  = '0;
                        end else begin
                            state_d = WRONG_PASS;
                        end
                    end
                end else if (timer_q == TMR_W'(WAIT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RIGHT_PASS: begin
                if (sensor_exit) begin
                    state_d = sensor_entrance ? STOP : IDLE;
                end
            end
            STOP: begin
                // Wrong submissions here are ignored and never reach the try counter
                if (pw_valid && pw_match) begin
                    state_d = full ? IDLE : RIGHT_PASS;
                end
            end
            LOCKOUT: begin
                if (lock_q == LCK_W'(LOCK_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q + LCK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous entry and departure cancel out; entry at capacity saturates
    always_comb begin
        occ_d = occ_q;
        if (entry_inc && !depart_dec) begin
            if (!full) begin
                occ_d = occ_q + OCC_W'(1);
            end
        end else if (depart_dec && !entry_inc) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    assign blink_d = (state_q == WRONG_PASS) ? ~blink_q : 1'b1;

    always_comb begin
        GREEN_LED = 1'b0;
        RED_LED   = 1'b1;
        case (state_q)
            IDLE:       RED_LED = full;
            WAIT_PASS:  RED_LED = 1'b1;
            WRONG_PASS: RED_LED = blink_q;
            RIGHT_PASS: begin
                GREEN_LED = 1'b1;
                RED_LED   = 1'b0;
            end
            STOP:       RED_LED = 1'b1;
            LOCKOUT:    RED_LED = 1'b1;
            default:    RED_LED = 1'b1;
        endcase
    end

    assign FULL      = full;
    assign LOCKED    = (state_q == LOCKOUT);
    assign occupancy = occ_q;

    assign free_slots  = 7'(CAPACITY) - 7'(occ_q);
    assign tens_digit  = 4'(free_slots / 7'd10);
    assign units_digit = 4'(free_slots % 7'd10);

    iiitb_seg7 u_seg_tens (
        .bcd_i (tens_digit),
        .seg_o (HEX_1)
    );

    iiitb_seg7 u_seg_units (
        .bcd_i (units_digit),
        .seg_o (HEX_2)
    );

endmodule

// File: tb/tb_iiitb_pcps.sv
// tb/tb_iiitb_pcps.sv - directed scenario bench for the parking controller
module tb_iiitb_pcps;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_entrance = 1'b0;
    logic       sensor_exit = 1'b0;
    logic       sensor_depart = 1'b0;
    logic [1:0] password_1 = 2'd0;
    logic [1:0] password_2 = 2'd0;
    logic       pw_valid = 1'b0;
    logic       GREEN_LED;
    logic       RED_LED;
    logic       FULL;
    logic       LOCKED;
    logic [3:0] occupancy;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;

    int errors = 0;
    int checks = 0;

    iiitb_pcps dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .sensor_depart   (sensor_depart),
        .password_1      (password_1),
        .password_2      (password_2),
        .pw_valid        (pw_valid),
        .GREEN_LED       (GREEN_LED),
        .RED_LED         (RED_LED),
        .FULL            (FULL),
        .LOCKED          (LOCKED),
        .occupancy       (occupancy),
        .HEX_1           (HEX_1),
        .HEX_2           (HEX_2)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [1:0] p1, input logic [1:0] p2);
        password_1 = p1;
        password_2 = p2;
        pw_valid   = 1'b1;
        tick();
        pw_valid   = 1'b0;
    endtask

    task automatic admit();
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        submit(2'd1, 2'd2);
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        checks++;
        if ({GREEN_LED, RED_LED, FULL, LOCKED} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_leds got=%b exp=0000", {GREEN_LED, RED_LED, FULL, LOCKED});
        end
        checks++;
        if (occupancy !== 4'd0) begin
            errors++;
            $display("FAIL reset_occ got=%0d exp=0", occupancy);
        end
        checks++;
        if (HEX_1 !== seg_ref(0) || HEX_2 !== seg_ref(9)) begin
            errors++;
            $display("FAIL reset_hex got=%b/%b exp=%b/%b", HEX_1, HEX_2, seg_ref(0), seg_ref(9));
        end
    endtask

    task automatic test_entry();
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        checks++;
        if (RED_LED !== 1'b1 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL entry_wait_leds got=g%b r%b exp=g0 r1", GREEN_LED, RED_LED);
        end
        submit(2'd1, 2'd2);
        checks++;
        if (GREEN_LED !== 1'b1 || RED_LED !== 1'b0) begin
            errors++;
            $display("FAIL entry_green got=g%b r%b exp=g1 r0", GREEN_LED, RED_LED);
        end
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
        checks++;
        if (occupancy !== 4'd1 || GREEN_LED !== 1'b0 || RED_LED !== 1'b0) begin
            errors++;
            $display("FAIL entry_done got=occ%0d g%b r%b exp=occ1 g0 r0", occupancy, GREEN_LED, RED_LED);
        end
        checks++;
        if (HEX_1 !== seg_ref(0) || HEX_2 !== seg_ref(8)) begin
            errors++;
            $display("FAIL entry_hex got=%b/%b exp=%b/%b", HEX_1, HEX_2, seg_ref(0), seg_ref(8));
        end
    endtask

    task automatic test_lockout();
        logic [3:0] red_seen;
        int bad;
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        submit(2'd0, 2'd0);
        red_seen[3] = RED_LED;
        tick();
        red_seen[2] = RED_LED;
        submit(2'd0, 2'd0);
        red_seen[1] = RED_LED;
        tick();
        red_seen[0] = RED_LED;
        checks++;
        if (red_seen !== 4'b1010 || LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL lock_blink got=%b locked=%b exp=1010 locked=0", red_seen, LOCKED);
        end
        submit(2'd0, 2'd0);
        checks++;
        if (LOCKED !== 1'b1 || RED_LED !== 1'b1 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL lock_enter got=l%b r%b g%b exp=l1 r1 g0", LOCKED, RED_LED, GREEN_LED);
        end
        sensor_entrance = 1'b1;
        password_1 = 2'd1;
        password_2 = 2'd2;
        pw_valid   = 1'b1;
        bad = 0;
        for (int k = 2; k <= 31; k++) begin
            tick();
            if (LOCKED !== 1'b1 || GREEN_LED !== 1'b0) bad++;
        end
        sensor_entrance = 1'b0;
        pw_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lock_hold got=%0d bad cycles exp=0", bad);
        end
        tick();
        checks++;
        if (LOCKED !== 1'b0 || RED_LED !== 1'b0 || GREEN_LED !== 1'b0 || occupancy !== 4'd1) begin
            errors++;
            $display("FAIL lock_exit got=l%b r%b g%b occ%0d exp=l0 r0 g0 occ1", LOCKED, RED_LED, GREEN_LED, occupancy);
        end
    endtask

    task automatic test_timeout();
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        repeat (14) tick();
        checks++;
        if (RED_LED !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got=%b exp=1", RED_LED);
        end
        tick();
        checks++;
        if (RED_LED !== 1'b0 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got=r%b g%b exp=r0 g0", RED_LED, GREEN_LED);
        end
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        repeat (10) tick();
        submit(2'd3, 2'd3);
        repeat (14) tick();
        submit(2'd1, 2'd2);
        checks++;
        if (GREEN_LED !== 1'b1) begin
            errors++;
            $display("FAIL timeout_restart got=%b exp=1", GREEN_LED);
        end
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
        checks++;
        if (occupancy !== 4'd2) begin
            errors++;
            $display("FAIL timeout_occ got=%0d exp=2", occupancy);
        end
    endtask

    task automatic test_tailgate();
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        submit(2'd1, 2'd2);
        sensor_entrance = 1'b1;
        sensor_exit     = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        sensor_exit     = 1'b0;
        checks++;
        if (occupancy !== 4'd3 || RED_LED !== 1'b1 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL tail_stop got=occ%0d r%b g%b exp=occ3 r1 g0", occupancy, RED_LED, GREEN_LED);
        end
        submit(2'd2, 2'd1);
        tick();
        checks++;
        if (RED_LED !== 1'b1 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL tail_wrong got=r%b g%b exp=r1 g0", RED_LED, GREEN_LED);
        end
        submit(2'd0, 2'd0);
        submit(2'd0, 2'd0);
        submit(2'd0, 2'd0);
        checks++;
        if (LOCKED !== 1'b0 || RED_LED !== 1'b1) begin
            errors++;
            $display("FAIL tail_no_tries got=l%b r%b exp=l0 r1", LOCKED, RED_LED);
        end
        submit(2'd1, 2'd2);
        checks++;
        if (GREEN_LED !== 1'b1) begin
            errors++;
            $display("FAIL tail_right got=%b exp=1", GREEN_LED);
        end
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
        checks++;
        if (occupancy !== 4'd4 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL tail_done got=occ%0d g%b exp=occ4 g0", occupancy, GREEN_LED);
        end
    endtask

    task automatic test_simultaneous();
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        submit(2'd1, 2'd2);
        sensor_exit   = 1'b1;
        sensor_depart = 1'b1;
        tick();
        sensor_exit   = 1'b0;
        sensor_depart = 1'b0;
        checks++;
        if (occupancy !== 4'd4 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL simul_occ got=occ%0d g%b exp=occ4 g0", occupancy, GREEN_LED);
        end
        sensor_depart = 1'b1;
        tick();
        sensor_depart = 1'b0;
        checks++;
        if (occupancy !== 4'd3 || HEX_1 !== seg_ref(0) || HEX_2 !== seg_ref(6)) begin
            errors++;
            $display("FAIL depart_occ got=occ%0d hex=%b/%b exp=occ3 hex=%b/%b", occupancy, HEX_1, HEX_2, seg_ref(0), seg_ref(6));
        end
    endtask

    task automatic test_full();
        repeat (6) admit();
        checks++;
        if (occupancy !== 4'd9 || FULL !== 1'b1 || RED_LED !== 1'b1) begin
            errors++;
            $display("FAIL full_reach got=occ%0d f%b r%b exp=occ9 f1 r1", occupancy, FULL, RED_LED);
        end
        checks++;
        if (HEX_1 !== seg_ref(0) || HEX_2 !== seg_ref(0)) begin
            errors++;
            $display("FAIL full_hex got=%b/%b exp=%b/%b", HEX_1, HEX_2, seg_ref(0), seg_ref(0));
        end
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        submit(2'd1, 2'd2);
        checks++;
        if (GREEN_LED !== 1'b0 || occupancy !== 4'd9) begin
            errors++;
            $display("FAIL full_blocked got=g%b occ%0d exp=g0 occ9", GREEN_LED, occupancy);
        end
        sensor_depart = 1'b1;
        tick();
        sensor_depart = 1'b0;
        checks++;
        if (FULL !== 1'b0 || occupancy !== 4'd8 || HEX_1 !== seg_ref(0) || HEX_2 !== seg_ref(1)) begin
            errors++;
            $display("FAIL full_depart got=f%b occ%0d hex=%b/%b exp=f0 occ8 hex=%b/%b", FULL, occupancy, HEX_1, HEX_2, seg_ref(0), seg_ref(1));
        end
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        submit(2'd1, 2'd2);
        sensor_entrance = 1'b1;
        sensor_exit     = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        sensor_exit     = 1'b0;
        submit(2'd1, 2'd2);
        checks++;
        if (GREEN_LED !== 1'b0 || FULL !== 1'b1) begin
            errors++;
            $display("FAIL stop_full got=g%b f%b exp=g0 f1", GREEN_LED, FULL);
        end
        sensor_depart = 1'b1;
        tick();
        sensor_depart = 1'b0;
        checks++;
        if (RED_LED !== 1'b0 || occupancy !== 4'd8) begin
            errors++;
            $display("FAIL stop_full_idle got=r%b occ%0d exp=r0 occ8", RED_LED, occupancy);
        end
    endtask

    task automatic test_reset_mid();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (4) admit();
        checks++;
        if (occupancy !== 4'd4) begin
            errors++;
            $display("FAIL mid_setup got=%0d exp=4", occupancy);
        end
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        submit(2'd1, 2'd2);
        reset_n     = 1'b0;
        sensor_exit = 1'b1;
        tick();
        checks++;
        if (occupancy !== 4'd0 || GREEN_LED !== 1'b0 || RED_LED !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=occ%0d g%b r%b exp=occ0 g0 r0", occupancy, GREEN_LED, RED_LED);
        end
        checks++;
        if (HEX_1 !== seg_ref(0) || HEX_2 !== seg_ref(9)) begin
            errors++;
            $display("FAIL mid_hex got=%b/%b exp=%b/%b", HEX_1, HEX_2, seg_ref(0), seg_ref(9));
        end
        reset_n     = 1'b1;
        sensor_exit = 1'b0;
        tick();
        sensor_depart = 1'b1;
        tick();
        sensor_depart = 1'b0;
        checks++;
        if (occupancy !== 4'd0 || GREEN_LED !== 1'b0) begin
            errors++;
            $display("FAIL underflow got=occ%0d g%b exp=occ0 g0", occupancy, GREEN_LED);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_lockout();
        test_timeout();
        test_tailgate();
        test_simultaneous();
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
